load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sequences lw/sw requests from the execute stage into the 8-entry data memory.
//  Accepts one request at a time over a valid/ready handshake and drives the data memory's
//  addr/wdata/write_en/read strobes for exactly one cycle per access.
//  Captures load data into a register and returns it to writeback with its destination register.
//  Flags out-of-range addresses and counts completed accesses.
// PARAMETERS
//  ADDR_W      8  request/memory address width
//  DATA_W      8  data width
//  RD_W        3  destination-register index width
//  DMEM_DEPTH  8  number of valid memory words; legal addresses are 0..DMEM_DEPTH-1
// PORTS
//  clk              in   1       system clock, all state updates on rising edge
//  rst_n            in   1       asynchronous active-low reset
//  req_valid        in   1       request present
//  req_ready        out  1       unit can accept (high only in IDLE)
//  req_we           in   1       1 = sw, 0 = lw
//  req_addr         in   ADDR_W  byte address (ALU result or immediate)
//  req_wdata        in   DATA_W  store data
//  req_rd           in   RD_W    load destination register
//  rsp_valid        out  1       load result available
//  rsp_ready        in   1       writeback accepts result
//  rsp_rdata        out  DATA_W  load data
//  rsp_rd           out  RD_W    load destination register
//  rsp_err          out  1       result belongs to an out-of-range load
//  mem_access_addr  out  ADDR_W  to data memory address input
//  mem_write_data   out  DATA_W  to data memory write data
//  mem_write_en     out  1       to data memory write enable
//  mem_read         out  1       to data memory read enable
//  mem_read_data    in   DATA_W  from data memory (combinational read)
//  err_flag         out  1       sticky: any out-of-range access since reset/clear
//  err_clr          in   1       synchronous clear of err_flag
//  acc_cnt          out  8       completed in-range accesses, wraps 255->0
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except req_ready=1; latched addr/data/rd cleared.
//  FSM IDLE -> ACCESS -> (IDLE | RESP) -> IDLE.
//  IDLE: req_ready=1; on req_valid, latch we/addr/wdata/rd; go to ACCESS.
//  ACCESS (exactly 1 cycle), with addr in range (addr < DMEM_DEPTH):
//   - store: mem_write_en=1; memory commits at the closing edge; next state IDLE.
//   - load: mem_read=1; mem_read_data is registered into rsp_rdata at the closing edge;
//     rsp_err=0; next state RESP.
//   - acc_cnt increments by 1 at the closing edge.
//  ACCESS with addr out of range:
//   - no strobe is asserted; err_flag is set.
//   - load: rsp_rdata=0, rsp_err=1; next state RESP. store: dropped; next state IDLE.
//  RESP: rsp_valid=1. rsp_rdata/rsp_rd/rsp_err are held stable until rsp_ready=1, then IDLE.
//  Latency: request accepted at edge E0.
//   - load: rsp_valid=1 after E1; if rsp_ready=1, IDLE after E2.
//   - store: write commits at E1; req_ready=1 again after E1.
//  mem_write_en and mem_read are never high together, and are high only in ACCESS.
//  mem_access_addr and mem_write_data hold their latched values outside ACCESS.
//  err_clr and a new error in the same cycle: set wins.
//  Async reset mid-ACCESS drops the strobes immediately; a pending response in RESP is discarded.
// TESTING
//  1. sw addr=3 data=0xA5, then lw addr=3 rd=2 -> write_en for 1 cycle at addr 3;
//     rsp_valid 2 cycles after load accept; rdata=0xA5, rd=2, err=0.
//  2. lw addr=5 with rsp_ready=0 for 4 cycles -> rsp_valid and rdata held;
//     req_ready=0 throughout; IDLE one edge after rsp_ready=1.
//  3. lw addr=0x09 -> no mem_read pulse; rsp_rdata=0, rsp_err=1, err_flag=1.
//     Then sw addr=0x10 -> no write_en, acc_cnt unchanged.
//  4. err_clr=1 in the same cycle as an out-of-range ACCESS -> err_flag stays 1;
//     err_clr alone next cycle -> 0.
//  5. 256 in-range stores -> acc_cnt returns to 0.
//     Back-to-back req_valid -> one accept per 2 cycles.
//  6. rst_n low during store ACCESS -> mem_write_en falls immediately and memory is unchanged.
//     rst_n low during RESP -> rsp_valid=0, state IDLE, req_ready=1.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store sequencer: one lw/sw at a time into an 8-word data memory, load result returned to writeback.
// Accept->ACCESS is one cycle; loads respond the cycle after ACCESS and hold until rsp_ready.
module load_store_unit #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_W       = 3,
    parameter int DMEM_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [RD_W-1:0]   rsp_rd,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              err_flag,
    input  logic              err_clr,
    output logic [7:0]        acc_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [ADDR_W:0] DEPTH_L = DMEM_DEPTH[ADDR_W:0];

    logic [1:0]        state;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [RD_W-1:0]   lat_rd;
    logic [DATA_W-1:0] rdata_q;
    logic              rerr_q;
    logic              err_q;
    logic [7:0]        cnt_q;
    logic              in_range;
    logic              in_access;

    assign in_range  = ({1'b0, lat_addr} < DEPTH_L);
    assign in_access = (state == S_ACCESS);

    // Strobes decode straight from state so an async reset kills them at once.
    assign req_ready       = (state == S_IDLE);
    assign rsp_valid       = (state == S_RESP);
    assign mem_write_en    = in_access & lat_we & in_range;
    assign mem_read        = in_access & ~lat_we & in_range;
    assign mem_access_addr = lat_addr;
    assign mem_write_data  = lat_wdata;
    assign rsp_rdata       = rdata_q;
    assign rsp_rd          = lat_rd;
    assign rsp_err         = rerr_q;
    assign err_flag        = err_q;
    assign acc_cnt         = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_rd    <= '0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_rd    <= req_rd;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (lat_we) begin
                        state <= S_IDLE;
                    end else begin
                        rdata_q <= in_range ? mem_read_data : '0;
                        rerr_q  <= ~in_range;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A fresh out-of-range access outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            if (in_access && !in_range) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
            if (in_access && in_range) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random lw/sw traffic checked against a transaction-level memory/counter model.
module tb_load_store_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_we;
    logic [7:0] req_addr, req_wdata;
    logic [2:0] req_rd;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic [2:0] rsp_rd;
    logic       rsp_err;
    logic [7:0] mem_access_addr, mem_write_data;
    logic       mem_write_en, mem_read;
    logic [7:0] mem_read_data;
    logic       err_flag, err_clr;
    logic [7:0] acc_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the memory should hold, the access count and the sticky error.
    logic [7:0] ref_mem [8];
    int         ref_cnt;
    bit         ref_err;

    // Environment data memory driven by the DUT strobes.
    logic [7:0] mem [8];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_access_addr[2:0]] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_access_addr[2:0]];

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data),
        .err_flag(err_flag), .err_clr(err_clr), .acc_cnt(acc_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic do_store(input logic [7:0] a, input logic [7:0] d, input bit clr_in_access);
        bit inr;
        inr = (a < 8);
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        err_clr   = clr_in_access;
        check("st_we", 32'(mem_write_en), 32'(inr));
        check("st_no_rd", 32'(mem_read), 32'd0);
        check("st_addr", 32'(mem_access_addr), 32'(a));
        check("st_busy", 32'(req_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        err_clr = 1'b0;
        if (inr) begin
            ref_mem[a[2:0]] = d;
            ref_cnt = (ref_cnt + 1) % 256;
            if (clr_in_access) ref_err = 1'b0;
        end else begin
            ref_err = 1'b1;
        end
        check("st_ready_again", 32'(req_ready), 32'd1);
        check("st_we_off", 32'(mem_write_en), 32'd0);
        check("st_acc_cnt", 32'(acc_cnt), 32'(ref_cnt));
        check("st_err_flag", 32'(err_flag), 32'(ref_err));
    endtask

    task automatic do_load(input logic [7:0] a, input logic [2:0] rd, input int hold);
        bit inr;
        logic [7:0] exp_d;
        inr = (a < 8);
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_rd = rd;
        req_wdata = 8'($urandom);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        check("ld_rd_strobe", 32'(mem_read), 32'(inr));
        check("ld_no_we", 32'(mem_write_en), 32'd0);
        check("ld_early_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        exp_d = inr ? ref_mem[a[2:0]] : 8'h00;
        if (inr) ref_cnt = (ref_cnt + 1) % 256;
        else     ref_err = 1'b1;
        check("ld_valid", 32'(rsp_valid), 32'd1);
        check("ld_rdata", 32'(rsp_rdata), 32'(exp_d));
        check("ld_rd", 32'(rsp_rd), 32'(rd));
        check("ld_err", 32'(rsp_err), 32'(!inr));
        check("ld_err_flag", 32'(err_flag), 32'(ref_err));
        check("ld_acc_cnt", 32'(acc_cnt), 32'(ref_cnt));
        check("ld_rd_off", 32'(mem_read), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", 32'(rsp_rdata), 32'(exp_d));
            check("hold_busy", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        check("ld_done_valid", 32'(rsp_valid), 32'd0);
        check("ld_done_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] old4, a, d;
        int         c0, accepts;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_rd = '0; rsp_ready = 1'b0; err_clr = 1'b0;
        ref_cnt = 0; ref_err = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_we", 32'(mem_write_en), 32'd0);
        check("rst_rd", 32'(mem_read), 32'd0);
        check("rst_err_flag", 32'(err_flag), 32'd0);
        check("rst_acc_cnt", 32'(acc_cnt), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_rd", 32'(rsp_rd), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_mem_addr", 32'(mem_access_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_write_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) do_store(8'(i), 8'($urandom), 1'b0);

        // Store then load back at the same address.
        do_store(8'd3, 8'hA5, 1'b0);
        do_load(8'd3, 3'd2, 0);
        check("t1_rdata", 32'(ref_mem[3]), 32'h0000_00A5);

        // Writeback stalls for four cycles.
        do_load(8'd5, 3'($urandom), 4);

        // Out-of-range load and store.
        do_load(8'h09, 3'd1, 0);
        c0 = ref_cnt;
        do_store(8'h10, 8'($urandom), 1'b0);
        check("t3_cnt_unchanged", 32'(acc_cnt), 32'(c0));

        // Clear colliding with a new error, then clear alone.
        do_store(8'h20, 8'h55, 1'b1);
        check("t4_set_wins", 32'(err_flag), 32'd1);
        err_clr = 1'b1;
        @(posedge clk); @(negedge clk);
        err_clr = 1'b0;
        ref_err = 1'b0;
        check("t4_clr", 32'(err_flag), 32'd0);

        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom_range(0, 11));
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_store(a, d, 1'($urandom_range(0, 1)));
            else                           do_load(a, 3'($urandom), int'($urandom_range(0, 2)));
        end

        // 256 counted accesses bring the counter back to its start value.
        c0 = ref_cnt;
        for (int i = 0; i < 256; i++) do_store(8'($urandom_range(0, 7)), 8'($urandom), 1'b0);
        check("t5_cnt_wrap", 32'(acc_cnt), 32'(c0));

        // Continuous request: accepts land every other cycle.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd1; req_wdata = 8'h3C;
        accepts = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_ready) accepts++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        ref_mem[1] = 8'h3C;
        ref_cnt = (ref_cnt + 5) % 256;
        check("t5_b2b_accepts", 32'(accepts), 32'd5);
        check("t5_b2b_cnt", 32'(acc_cnt), 32'(ref_cnt));
        do_load(8'd1, 3'd7, 0);

        // Reset during a store ACCESS.
        old4 = ref_mem[4];
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd4; req_wdata = ~old4;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        check("t6_we_before_rst", 32'(mem_write_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_we_dropped", 32'(mem_write_en), 32'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        ref_cnt = 0; ref_err = 1'b0;
        check("t6_mem_kept", 32'(mem[4]), 32'(old4));
        check("t6_cnt_reset", 32'(acc_cnt), 32'd0);
        check("t6_ready", 32'(req_ready), 32'd1);

        // Reset while a response is pending.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd2; req_rd = 3'd4;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("t6_resp_pending", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_resp_dropped", 32'(rsp_valid), 32'd0);
        check("t6_resp_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_still_idle", 32'(rsp_valid), 32'd0);
        do_load(8'd4, 3'd5, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
